// File: rtl/ram_req_ctrl_if.sv
// ram_req_ctrl_if: request/response channel
// of the buffered byte-enable RAM controller.
interface ram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_W-1:0]       req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output req_be,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_we,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_we,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: single-port word RAM with byte
// enables, range check, 2-deep response queue.
module ram_req_ctrl #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 256,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_req_ctrl_if.slave bus,
  output logic          init_done
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  we;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  state_t                state;
  logic [IDX_W-1:0]      init_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rsp_t                  q [2];
  rsp_t                  head;
  rsp_t                  entry;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [1:0]            count_nxt;

  logic                  push;
  logic                  pop;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  assign in_range = {1'b0, bus.req_addr} < LIMIT;
  assign idx      = bus.req_addr[IDX_W-1:0];

  // Queue occupancy after this edge; equals the
  // number of accepted but unpopped requests.
  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      (push && !pop): count_nxt = count + 2'd1;
      (pop && !push): count_nxt = count - 2'd1;
      default:        count_nxt = count;
    endcase
  end

  // Response formed at acceptance; the read sees
  // every write that landed on an earlier edge.
  always_comb begin
    entry     = '0;
    entry.we  = bus.req_we;
    entry.err = !in_range;
    if (!bus.req_we && in_range) begin
      entry.rdata = mem[idx];
    end
  end

  // Control FSM, queue pointers and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT_ON_RESET ? S_INIT : S_RUN;
      init_ptr      <= '0;
      init_done     <= !INIT_ON_RESET;
      bus.req_ready <= 1'b0;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      q[0]          <= '0;
      q[1]          <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST) begin
            state         <= S_RUN;
            init_done     <= 1'b1;
            bus.req_ready <= 1'b1;
          end
        end
        S_RUN: begin
          bus.req_ready <= (count_nxt < 2'd2);
        end
        default: begin
          state <= S_RUN;
        end
      endcase
      if (push) begin
        q[wr_ptr] <= entry;
        wr_ptr    <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_nxt;
    end
  end

  // Storage: zero sweep during INIT, then
  // byte-masked writes on accepted requests.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[init_ptr] <= '0;
    end else if (push && bus.req_we && in_range) begin
      for (int k = 0; k < BE_W; k++) begin
        if (bus.req_be[k]) begin
          mem[idx][8*k +: 8] <= bus.req_wdata[8*k +: 8];
        end
      end
    end
  end

  assign head = q[rd_ptr];

  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_we    = bus.rsp_valid && head.we;
  assign bus.rsp_err   = bus.rsp_valid && head.err;
  assign bus.rsp_rdata =
    bus.rsp_valid ? head.rdata : '0;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: directed vectors for the
// buffered byte-enable RAM controller.
module tb_ram_req_ctrl;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  logic done_a;
  logic done_b;

  int n_vec = 0;
  int n_err = 0;

  ram_req_ctrl_if #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32)
  ) ifa ();
  ram_req_ctrl_if #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32)
  ) ifb ();

  ram_req_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .DEPTH(16), .INIT_ON_RESET(1'b1)
  ) u_a (
    .clk(clk), .rst_n(rst_a_n),
    .bus(ifa), .init_done(done_a)
  );

  ram_req_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .DEPTH(200), .INIT_ON_RESET(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_b_n),
    .bus(ifb), .init_done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic set_req(
    input int          s,
    input logic        v,
    input logic        we,
    input logic [7:0]  ad,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    if (s == 0) begin
      ifa.req_valid = v;
      ifa.req_we    = we;
      ifa.req_addr  = ad;
      ifa.req_wdata = wd;
      ifa.req_be    = be;
    end else begin
      ifb.req_valid = v;
      ifb.req_we    = we;
      ifb.req_addr  = ad;
      ifb.req_wdata = wd;
      ifb.req_be    = be;
    end
  endtask

  function automatic logic f_ready(input int s);
    return (s == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction

  function automatic logic f_valid(input int s);
    return (s == 0) ? ifa.rsp_valid : ifb.rsp_valid;
  endfunction

  // One request, one response, rsp_ready high.
  task automatic xact(
    input  int          s,
    input  logic        we,
    input  logic [7:0]  ad,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    output logic        rwe,
    output logic [31:0] rd,
    output logic        er
  );
    int n;
    set_req(s, 1'b1, we, ad, wd, be);
    if (s == 0) ifa.rsp_ready = 1'b1;
    else        ifb.rsp_ready = 1'b1;
    n = 0;
    while (!f_ready(s) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("xact_ready_wait", 0, 1);
    @(negedge clk);
    set_req(s, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    n = 0;
    while (!f_valid(s) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("xact_rsp_latency", 64'(n), 0);
    if (s == 0) begin
      rwe = ifa.rsp_we;
      rd  = ifa.rsp_rdata;
      er  = ifa.rsp_err;
    end else begin
      rwe = ifb.rsp_we;
      rd  = ifb.rsp_rdata;
      er  = ifb.rsp_err;
    end
    @(negedge clk);
  endtask

  // Counts low-ready cycles after a release.
  task automatic init_len(output int cnt);
    cnt = 0;
    while (!ifa.req_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    logic        rwe;
    logic [31:0] rd;
    logic        er;
    int          cnt;
    int          bad;
    logic [31:0] d;

    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    ifa.rsp_ready = 1'b1;
    ifb.rsp_ready = 1'b1;
    #2;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", ifa.req_ready, 0);
    chk("rst_rsp_valid", ifa.rsp_valid, 0);
    chk("rst_rsp_we", ifa.rsp_we, 0);
    chk("rst_rsp_rdata", ifa.rsp_rdata, 0);
    chk("rst_rsp_err", ifa.rsp_err, 0);
    chk("rst_init_done", done_a, 0);
    chk("rst_init_done_b", done_b, 0);

    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    init_len(cnt);
    chk("t1_init_cycles", 64'(cnt), 16);
    chk("t1_init_done", done_a, 1);
    for (int i = 0; i < 16; i++) begin
      xact(0, 1'b0, 8'(i), 32'h0, 4'h0,
           rwe, rd, er);
      chk("t1_rdata", rd, 0);
      chk("t1_err", er, 0);
    end

    xact(0, 1'b1, 8'd5, 32'hAABBCCDD, 4'hF,
         rwe, rd, er);
    chk("t2_wr_we", rwe, 1);
    chk("t2_wr_rdata", rd, 0);
    xact(0, 1'b1, 8'd5, 32'h11223344, 4'b0101,
         rwe, rd, er);
    xact(0, 1'b0, 8'd5, 32'h0, 4'h0,
         rwe, rd, er);
    chk("t2_rd_we", rwe, 0);
    chk("t2_rd_data", rd, 32'hAA22CC44);
    chk("t2_rd_err", er, 0);

    ifa.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 32'h12345678 + 32'(i & ~1);
      set_req(0, 1'b1, (i % 2) == 0, 8'd3,
              d, 4'hF);
      chk("t3_ready", ifa.req_ready, 1);
      @(negedge clk);
      chk("t3_valid", ifa.rsp_valid, 1);
      chk("t3_we", ifa.rsp_we, (i % 2) == 0);
      chk("t3_rdata", ifa.rsp_rdata,
          ((i % 2) == 0) ? 32'h0 : d);
    end
    set_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t3_drain", ifa.rsp_valid, 0);

    ifa.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    chk("t4_ready0", ifa.req_ready, 1);
    @(negedge clk);
    chk("t4_ready1", ifa.req_ready, 1);
    chk("t4_valid1", ifa.rsp_valid, 1);
    set_req(0, 1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'd20, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_full_ready", ifa.req_ready, 0);
      chk("t4_hold_valid", ifa.rsp_valid, 1);
      chk("t4_hold_rdata", ifa.rsp_rdata,
          32'hAA22CC44);
      @(negedge clk);
    end
    ifa.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_second", ifa.rsp_rdata, 32'h1234567E);
    chk("t4_resume", ifa.req_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    chk("t4_third_valid", ifa.rsp_valid, 1);
    chk("t4_third_err", ifa.rsp_err, 1);
    chk("t4_third_rdata", ifa.rsp_rdata, 0);
    @(negedge clk);
    chk("t4_empty", ifa.rsp_valid, 0);

    xact(1, 1'b0, 8'd250, 32'h0, 4'h0,
         rwe, rd, er);
    chk("t5_rd250_err", er, 1);
    chk("t5_rd250_data", rd, 0);
    xact(1, 1'b1, 8'd199, 32'hCAFEF00D, 4'hF,
         rwe, rd, er);
    chk("t5_wr199_err", er, 0);
    xact(1, 1'b1, 8'd250, 32'hFFFFFFFF, 4'hF,
         rwe, rd, er);
    chk("t5_wr250_err", er, 1);
    chk("t5_wr250_we", rwe, 1);
    xact(1, 1'b0, 8'd199, 32'h0, 4'h0,
         rwe, rd, er);
    chk("t5_rd199", rd, 32'hCAFEF00D);
    xact(1, 1'b0, 8'd200, 32'h0, 4'h0,
         rwe, rd, er);
    chk("t5_rd200_err", er, 1);
    bad = 0;
    for (int i = 0; i < 199; i++) begin
      xact(1, 1'b0, 8'(i), 32'h0, 4'h0,
           rwe, rd, er);
      if (rd != 32'h0 || er) bad++;
    end
    chk("t5_sweep", 64'(bad), 0);

    @(negedge clk);
    rst_a_n = 1'b0;
    #1;
    chk("t6_rst_ready", ifa.req_ready, 0);
    chk("t6_rst_done", done_a, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_mid_init", ifa.req_ready, 0);
    rst_a_n = 1'b0;
    #1;
    chk("t6_mid_rst_ready", ifa.req_ready, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    init_len(cnt);
    chk("t6_init_cycles1", 64'(cnt), 16);

    ifa.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    set_req(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    chk("t6_q_valid", ifa.rsp_valid, 1);
    chk("t6_q_full", ifa.req_ready, 0);
    rst_a_n = 1'b0;
    #1;
    chk("t6_q_rst_valid", ifa.rsp_valid, 0);
    chk("t6_q_rst_ready", ifa.req_ready, 0);
    chk("t6_q_rst_rdata", ifa.rsp_rdata, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    init_len(cnt);
    chk("t6_init_cycles2", 64'(cnt), 16);
    xact(0, 1'b0, 8'd3, 32'h0, 4'h0,
         rwe, rd, er);
    chk("t6_zeroed", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Parametrised successor to the team's single-port byte RAM. It adds a valid/ready request channel, per-byte write enables, a buffered response channel with backpressure, and address range checking. An optional post-reset sweep zero-fills the array. It sits between a bus master or arbiter and on-chip storage.

Parameters:
ADDR_WIDTH, 8, request address width.
DATA_WIDTH, 32, word width. Must be a multiple of 8.
DEPTH, 256, number of words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
INIT_ON_RESET, 1, when 1 the array is zero-filled after reset before requests are accepted.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request can be accepted this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  word address.
req_wdata  in  DATA_WIDTH  write data.
req_be  in  DATA_WIDTH/8  byte enables; bit k covers byte k (bits 8k+7:8k).
rsp_valid  out  1  response present at the head of the response queue.
rsp_ready  in  1  consumer accepts the response.
rsp_we  out  1  echo of req_we for this response.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
rsp_err  out  1  address was >= DEPTH.
init_done  out  1  zero-fill complete; stays high until the next reset.

Behaviour:
- Reset is asynchronous on rst_n low. Required values while in reset:
  - req_ready=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0.
  - init_done = 0 if INIT_ON_RESET=1, else 1.
  - Response queue and outstanding count cleared; the FSM enters INIT (or RUN if INIT_ON_RESET=0).
  - Array contents are not reset.
- FSM states:
  - INIT: an internal pointer runs from 0 to DEPTH-1 and writes one all-zero word per cycle. req_ready=0 throughout. After the write to DEPTH-1, the next cycle enters RUN with init_done=1. INIT lasts exactly DEPTH cycles.
  - RUN: normal operation. There is no exit except reset.
- Handshakes:
  - A request is accepted when req_valid && req_ready.
  - A response is popped when rsp_valid && rsp_ready.
- Outstanding count:
  - outstanding = requests accepted but not yet popped, range 0..2.
  - req_ready = (state==RUN) && (outstanding < 2). It is registered and does not depend combinationally on rsp_ready.
- Accepted write with in-range address: each byte k with req_be[k]=1 is updated at the acceptance edge; bytes with req_be[k]=0 are unchanged. req_be=0 is a legal no-op write that still produces a response.
- Accepted read with in-range address: the response carries the array word as it stood after all earlier accepted writes. A read accepted the cycle after a write to the same address returns the new data.
- Address >= DEPTH: no array access; the response has rsp_err=1 and rsp_rdata=0. This only applies when DEPTH < 2**ADDR_WIDTH.
- Latency and ordering:
  - Each accepted request produces exactly one response, in order.
  - Earliest rsp_valid is 1 cycle after acceptance.
  - With rsp_ready held at 1, sustained throughput is 1 request per cycle.
- Response queue:
  - 2-entry FIFO of {we, rdata, err}.
  - rsp_* outputs are driven from the queue head and hold stable while rsp_valid=1 and rsp_ready=0.
  - Enqueue and pop in the same cycle leave the occupancy unchanged.
- Full queue: with outstanding=2, req_ready=0 until a pop. req_ready returns to 1 the cycle after the pop.
- Input changes while req_ready=0 have no effect.
- Reset mid-operation: queued responses are discarded, an in-progress INIT restarts from address 0, and a write at the reset edge may or may not have landed.

Test Plan:
1. INIT_ON_RESET=1, DEPTH=16: release rst_n -> req_ready=0 for exactly 16 cycles, then init_done=1 and req_ready=1. Reading every address -> rdata=0, rsp_err=0.
2. Write addr 5, wdata 0xAABBCCDD, be=4'hF; then write addr 5, wdata 0x11223344, be=4'b0101. Read addr 5 -> rdata=0xAA22CC44.
3. rsp_ready=1, back-to-back write addr 3 = 0x12345678 then read addr 3 on the next cycle -> read response 0x12345678 one cycle after its acceptance. No bubbles across 8 alternating requests.
4. rsp_ready=0, req_valid held high -> exactly 2 requests accepted, then req_ready=0. rsp_* stays stable. Raising rsp_ready -> both responses in order, and acceptance resumes the cycle after the first pop.
5. DEPTH=200, ADDR_WIDTH=8: read addr 250 -> rsp_err=1, rdata=0. Write addr 250 -> rsp_err=1, and addresses 0..199 are unchanged.
6. Assert rst_n low mid-INIT and again with 2 responses queued -> rsp_valid=0 and req_ready=0 immediately. The INIT sweep restarts and lasts the full DEPTH cycles.
